// File: rtl/control_sequencer.sv
// Hardwired Moore control unit that steps fetch/decode/execute and drives every DataPath strobe.
// The state and the strobes are registered on the falling clock edge so that they are stable at each rising DataPath edge.
module control_sequencer #(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        IncPC,
  output logic        ZLOout,
  output logic        ZLOin,
  output logic        Cout,
  output logic        MDRout,
  output logic        RAMenable,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15in,
  output logic        read,
  output logic        write,
  output logic        conin,
  output logic        OutPortenable,
  output logic        PortInout,
  output logic [4:0]  aluControl
);

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       inc_pc;
    logic       zlo_out;
    logic       zlo_in;
    logic       c_out;
    logic       mdr_out;
    logic       ram_en;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       r15_in;
    logic       rd;
    logic       wr;
    logic       con_in;
    logic       out_port_en;
    logic       port_inout;
    logic [4:0] alu;
  } ctrl_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b01001, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011, OP_JR   = 5'b10100, OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_HALT = 5'b11011;

  // Final step of each instruction; nop, halt and unknown opcodes end at T2.
  function automatic state_t last_step(input logic [4:0] op);
    state_t s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: s = S_T5;
      OP_LD, OP_ST:                     s = S_T7;
      OP_BR:                            s = S_T6;
      OP_JAL:                           s = S_T4;
      OP_JR, OP_IN, OP_OUT:             s = S_T3;
      default:                          s = S_T2;
    endcase
    return s;
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic [4:0] op, input logic con);
    ctrl_t c;
    c = '0;
    case (st)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
      S_T1: begin c.rd = 1'b1; c.ram_en = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
            begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          OP_LDI, OP_LD, OP_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
          OP_BR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
          OP_JAL: begin c.r15_in = 1'b1; c.pc_out = 1'b1; end
          OP_JR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          OP_IN:  begin c.port_inout = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          OP_OUT: begin c.gra = 1'b1; c.r_out = 1'b1; c.out_port_en = 1'b1; end
          default: c = '0;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL:
            begin c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; c.alu = op; end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin c.c_out = 1'b1; c.zlo_in = 1'b1; c.alu = OP_ADD; end
          OP_ANDI: begin c.c_out = 1'b1; c.zlo_in = 1'b1; c.alu = OP_AND; end
          OP_ORI:  begin c.c_out = 1'b1; c.zlo_in = 1'b1; c.alu = OP_OR; end
          OP_BR:   begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          OP_JAL:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          default: c = '0;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
            begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          OP_LD, OP_ST: begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
          OP_BR:        begin c.c_out = 1'b1; c.zlo_in = 1'b1; c.alu = OP_ADD; end
          default: c = '0;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD: begin c.rd = 1'b1; c.ram_en = 1'b1; c.mdr_in = 1'b1; end
          OP_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
          OP_BR: begin c.zlo_out = 1'b1; c.pc_in = con; end
          default: c = '0;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          OP_ST: begin c.wr = 1'b1; c.ram_en = 1'b1; end
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [4:0]  op_s;
  logic [26:0] unused_ir_s;
  state_t      state_q, state_d;
  logic        live_q, live_d;
  logic        run_q, run_d;
  ctrl_t       ctrl_q, ctrl_d;

  assign op_s        = IR[31:27];
  assign unused_ir_s = IR[26:0];

  // Next step and the strobes that belong to it; live_q holds T0 for one edge after clear releases.
  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    ctrl_d  = '0;
    run_d   = 1'b1;
    if (!live_q) begin
      state_d = S_T0;
    end else if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if ((state_q == S_T2) && (op_s == OP_HALT)) begin
      state_d = S_HALT;
    end else if (state_q == last_step(op_s)) begin
      state_d = stop ? S_HALT : S_T0;
    end else begin
      state_d = state_t'(state_q + 4'd1);
    end
    if (state_d == S_HALT) begin
      ctrl_d = '0;
      run_d  = 1'b0;
    end else begin
      ctrl_d = decode(state_d, op_s, CON_FF);
      run_d  = 1'b1;
    end
  end

  // State and strobe registers, falling-edge clocked so DataPath sees settled controls.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_T0;
      live_q  <= 1'b0;
      run_q   <= 1'b1;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      run_q   <= run_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign run           = run_q;
  assign PCout         = ctrl_q.pc_out;
  assign IncPC         = ctrl_q.inc_pc;
  assign ZLOout        = ctrl_q.zlo_out;
  assign ZLOin         = ctrl_q.zlo_in;
  assign Cout          = ctrl_q.c_out;
  assign MDRout        = ctrl_q.mdr_out;
  assign RAMenable     = ctrl_q.ram_en;
  assign MARin         = ctrl_q.mar_in;
  assign PCin          = ctrl_q.pc_in;
  assign MDRin         = ctrl_q.mdr_in;
  assign IRin          = ctrl_q.ir_in;
  assign Yin           = ctrl_q.y_in;
  assign Gra           = ctrl_q.gra;
  assign Grb           = ctrl_q.grb;
  assign Grc           = ctrl_q.grc;
  assign Rin           = ctrl_q.r_in;
  assign Rout          = ctrl_q.r_out;
  assign BAout         = ctrl_q.ba_out;
  assign R15in         = ctrl_q.r15_in;
  assign read          = ctrl_q.rd;
  assign write         = ctrl_q.wr;
  assign conin         = ctrl_q.con_in;
  assign OutPortenable = ctrl_q.out_port_en;
  assign PortInout     = ctrl_q.port_inout;
  assign aluControl    = ctrl_q.alu;

endmodule
